prng_bytepipe_multi: RTL and testbench

Multi-channel successor to the single-generator bytepipe PRNG: NCHAN independent Xoroshiro128+ generators behind one bytepipe command port (USB-serial bridge side). Adds:
- per-channel reseeding;
- a software run/stop control;
- three output modes: raw byte, sign-pack, Bernoulli threshold;
- auto-incrementing burst reads of generator state.

---
 rtl/prng_bytepipe_multi_pkg.sv | 39 +++
 rtl/prng_xoroshiro128p_ar.sv | 45 ++++
 rtl/prng_bytepipe_multi.sv | 165 ++++++++++++++++
 tb/tb_prng_bytepipe_multi.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_bytepipe_multi_pkg.sv
// Shared constants, encodings and types for the multi-channel bytepipe PRNG.
package prng_bytepipe_multi_pkg;

    localparam logic [63:0] SEED0_DEF = 64'h0123456789abcdef;
    localparam logic [63:0] SEED1_DEF = 64'hfedcba9876543210;

    localparam logic [6:0] ADDR_BURST    = 7'h00;
    localparam logic [6:0] ADDR_CHSEL    = 7'h01;
    localparam logic [6:0] ADDR_MODE     = 7'h02;
    localparam logic [6:0] ADDR_THRESH   = 7'h03;
    localparam logic [6:0] ADDR_SEED     = 7'h04;
    localparam logic [6:0] ADDR_SEEDLOAD = 7'h05;
    localparam logic [6:0] ADDR_RUN      = 7'h06;
    localparam logic [6:0] ADDR_RESULT   = 7'h10;
    // addr[6:4] of the 0x20..0x2F generator-state window
    localparam logic [2:0] ADDR_STATE_HI = 3'b010;

    localparam logic [1:0] MODE_RAW    = 2'd0;
    localparam logic [1:0] MODE_SIGN   = 2'd1;
    localparam logic [1:0] MODE_THRESH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRDATA,
        ST_RESP
    } bpState_t;

    typedef struct packed {
        logic [7:0] burst;
        logic [1:0] mode;
        logic [7:0] thresh;
        logic       run;
    } ctrlRegs_t;

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned k);
        return (x << k) | (x >> (64 - k));
    endfunction

endpackage

// File: rtl/prng_xoroshiro128p_ar.sv
// One Xoroshiro128+ generator; result is combinational from current state, state steps once per enabled cycle.
// Seed load has priority over advance; no backpressure, the caller gates i_load/i_adv.
module prng_xoroshiro128p_ar
    import prng_bytepipe_multi_pkg::*;
#(
    parameter logic [63:0] RST_S0 = SEED0_DEF,
    parameter logic [63:0] RST_S1 = SEED1_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [63:0] i_seedS0,
    input  logic [63:0] i_seedS1,
    input  logic        i_adv,
    output logic [63:0] o_s0,
    output logic [63:0] o_s1,
    output logic [63:0] o_result
);

    logic [63:0] s0Q, s1Q, mixS1, s0Nxt, s1Nxt;

    always_comb begin
        mixS1 = s1Q ^ s0Q;
        s0Nxt = rotl64(s0Q, 24) ^ mixS1 ^ (mixS1 << 16);
        s1Nxt = rotl64(mixS1, 37);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s0Q <= RST_S0;
            s1Q <= RST_S1;
        end else if (i_load) begin
            s0Q <= i_seedS0;
            s1Q <= i_seedS1;
        end else if (i_adv) begin
            s0Q <= s0Nxt;
            s1Q <= s1Nxt;
        end
    end

    assign o_s0     = s0Q;
    assign o_s1     = s1Q;
    assign o_result = s0Q + s1Q;

endmodule

// File: rtl/prng_bytepipe_multi.sv
// NCHAN Xoroshiro128+ generators behind a bytepipe register port; response registered one cycle after accept,
// bursts stream one byte per cycle; o_bp_ready is low while a response is held waiting for i_bp_ready.
module prng_bytepipe_multi
    import prng_bytepipe_multi_pkg::*;
#(
    parameter int          NCHAN = 4,
    parameter logic [63:0] SEED0 = SEED0_DEF,
    parameter logic [63:0] SEED1 = SEED1_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cg,
    input  logic [7:0] i_bp_data,
    input  logic       i_bp_valid,
    output logic       o_bp_ready,
    output logic [7:0] o_bp_data,
    output logic       o_bp_valid,
    input  logic       i_bp_ready
);

    localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    bpState_t        stateQ, stateNxt;
    ctrlRegs_t       regsQ;
    logic [CHW-1:0]  chselQ;
    logic [127:0]    seedQ;
    logic [6:0]      addrQ, burstAddr, rdAddr;
    logic            isWriteQ;
    logic [7:0]      respQ, respNxt, rdVal, result, signBits, thrBits;
    logic [63:0]     genS0 [NCHAN];
    logic [63:0]     genS1 [NCHAN];
    logic [63:0]     genR  [NCHAN];
    logic [63:0]     selR, loadS0, loadS1;
    logic [127:0]    selS, stateShift;
    logic            cmdAccept, dataAccept, outAccept, burstMore, seedLoad;

    assign cmdAccept  = i_bp_valid & o_bp_ready & (stateQ == ST_IDLE);
    assign dataAccept = i_bp_valid & o_bp_ready & (stateQ == ST_WRDATA);
    assign outAccept  = o_bp_valid & i_bp_ready;
    assign burstMore  = !isWriteQ && (regsQ.burst != 8'd0) && (addrQ != ADDR_BURST);
    assign burstAddr  = (addrQ[6:4] == ADDR_STATE_HI) ? {addrQ[6:4], addrQ[3:0] + 4'd1} : addrQ;
    assign seedLoad   = i_cg & dataAccept & (addrQ == ADDR_SEEDLOAD);
    // An all-zero state would lock the generator at zero forever
    assign loadS0     = (seedQ == 128'd0) ? 64'd1 : seedQ[63:0];
    assign loadS1     = (seedQ == 128'd0) ? 64'd0 : seedQ[127:64];

    for (genvar c = 0; c < NCHAN; c++) begin : g_gen
        prng_xoroshiro128p_ar #(
            .RST_S0 (SEED0 ^ 64'(c)),
            .RST_S1 (SEED1)
        ) u_gen (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_load   (seedLoad && (chselQ == CHW'(c))),
            .i_seedS0 (loadS0),
            .i_seedS1 (loadS1),
            .i_adv    (i_cg & regsQ.run),
            .o_s0     (genS0[c]),
            .o_s1     (genS1[c]),
            .o_result (genR[c])
        );
    end

    always_comb begin
        selR     = '0;
        selS     = '0;
        signBits = '0;
        thrBits  = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (chselQ == CHW'(c)) begin
                selR = genR[c];
                selS = {genS1[c], genS0[c]};
            end
            signBits[3'(c)] = genR[c][63];
            thrBits[3'(c)]  = genR[c][63:56] < regsQ.thresh;
        end
        case (regsQ.mode)
            MODE_RAW:    result = selR[63:56];
            MODE_SIGN:   result = signBits;
            MODE_THRESH: result = thrBits;
            default:     result = selR[63:56];
        endcase
    end

    // One read mux serves command accept, write-previous-value and burst reload
    always_comb begin
        case (stateQ)
            ST_IDLE:   rdAddr = i_bp_data[6:0];
            ST_WRDATA: rdAddr = addrQ;
            default:   rdAddr = burstAddr;
        endcase
        stateShift = selS >> {rdAddr[3:0], 3'b000};
        rdVal      = 8'd0;
        if (rdAddr[6:4] == ADDR_STATE_HI) begin
            rdVal = stateShift[7:0];
        end else begin
            case (rdAddr)
                ADDR_CHSEL:  rdVal = 8'(chselQ);
                ADDR_MODE:   rdVal = {6'd0, regsQ.mode};
                ADDR_THRESH: rdVal = regsQ.thresh;
                ADDR_RUN:    rdVal = {7'd0, regsQ.run};
                ADDR_RESULT: rdVal = result;
                default:     rdVal = 8'd0;
            endcase
        end
        respNxt = (stateQ == ST_WRDATA && addrQ == ADDR_BURST) ? regsQ.burst : rdVal;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) stateQ <= ST_IDLE;
        else if (i_cg) stateQ <= stateNxt;
    end

    always_comb begin
        stateNxt = stateQ;
        case (stateQ)
            ST_IDLE:   if (i_bp_valid) stateNxt = i_bp_data[7] ? ST_WRDATA : ST_RESP;
            ST_WRDATA: if (i_bp_valid) stateNxt = ST_RESP;
            ST_RESP:   if (i_bp_ready && !burstMore) stateNxt = ST_IDLE;
            default:   stateNxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_bp_ready = (stateQ != ST_RESP);
        o_bp_valid = (stateQ == ST_RESP);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            regsQ    <= '0;
            chselQ   <= '0;
            seedQ    <= '0;
            addrQ    <= '0;
            isWriteQ <= 1'b0;
            respQ    <= 8'd0;
        end else if (i_cg) begin
            if (cmdAccept) begin
                addrQ    <= i_bp_data[6:0];
                isWriteQ <= i_bp_data[7];
                if (!i_bp_data[7]) respQ <= respNxt;
            end
            if (dataAccept) begin
                respQ <= respNxt;
                case (addrQ)
                    ADDR_BURST:  regsQ.burst  <= i_bp_data;
                    ADDR_CHSEL:  chselQ       <= i_bp_data[CHW-1:0];
                    ADDR_MODE:   regsQ.mode   <= i_bp_data[1:0];
                    ADDR_THRESH: regsQ.thresh <= i_bp_data;
                    ADDR_SEED:   seedQ        <= {seedQ[119:0], i_bp_data};
                    ADDR_RUN:    regsQ.run    <= i_bp_data[0];
                    default: ;
                endcase
            end
            if (outAccept && burstMore) begin
                regsQ.burst <= regsQ.burst - 8'd1;
                addrQ       <= burstAddr;
                respQ       <= respNxt;
            end
        end
    end

    assign o_bp_data = respQ;

endmodule

// File: tb/tb_prng_bytepipe_multi.sv
// Bench for prng_bytepipe_multi: directed register-map walk then random traffic against an
// arithmetic reference of the register map and Xoroshiro128+ generators, checked through a response scoreboard.
module tb_prng_bytepipe_multi;

    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rst, cg, inVld, bpRdyIn;
    logic [7:0] inDat;
    logic       outRdy, outVld;
    logic [7:0] outDat;

    int tests = 0;
    int fails = 0;

    logic [7:0] expQ [$];
    logic       holdRdy = 1'b0;
    logic       rndRdy = 1'b0;

    // reference model state
    logic [63:0]  mS0 [NCH];
    logic [63:0]  mS1 [NCH];
    logic [7:0]   mBurst, mThresh;
    logic [1:0]   mMode, mChsel;
    logic         mRun;
    logic [127:0] mSeed;

    prng_bytepipe_multi #(.NCHAN(NCH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cg       (cg),
        .i_bp_data  (inDat),
        .i_bp_valid (inVld),
        .o_bp_ready (outRdy),
        .o_bp_data  (outDat),
        .o_bp_valid (outVld),
        .i_bp_ready (bpRdyIn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] xoroNext(input logic [127:0] st);
        logic [63:0] a, b;
        a = st[63:0];
        b = st[127:64];
        b = b ^ a;
        a = {a[39:0], a[63:40]} ^ b ^ (b << 16);
        b = {b[26:0], b[63:27]};
        return {b, a};
    endfunction

    task automatic resetModel();
        for (int c = 0; c < NCH; c++) begin
            mS0[c] = 64'h0123456789abcdef ^ 64'(c);
            mS1[c] = 64'hfedcba9876543210;
        end
        mBurst = 0; mThresh = 0; mMode = 0; mChsel = 0; mRun = 0; mSeed = 0;
    endtask

    // Register value as seen k cycles after the current edge
    function automatic logic [7:0] readAt(input logic [6:0] a, input int k);
        logic [63:0]  s0 [NCH];
        logic [63:0]  s1 [NCH];
        logic [127:0] t;
        logic [63:0]  r;
        logic [7:0]   res;
        for (int c = 0; c < NCH; c++) begin
            t = {mS1[c], mS0[c]};
            if (mRun) for (int j = 0; j < k; j++) t = xoroNext(t);
            s0[c] = t[63:0];
            s1[c] = t[127:64];
        end
        res = 0;
        if (mMode == 2'd1) begin
            for (int c = 0; c < NCH; c++) begin
                r = s0[c] + s1[c];
                res[c] = r[63];
            end
        end else if (mMode == 2'd2) begin
            for (int c = 0; c < NCH; c++) begin
                r = s0[c] + s1[c];
                res[c] = (r >> 56) < 64'(mThresh);
            end
        end else begin
            r = (s0[mChsel] + s1[mChsel]) >> 56;
            res = r[7:0];
        end
        if (a >= 7'h20 && a <= 7'h2F) begin
            t = {s1[mChsel], s0[mChsel]} >> (8 * int'(a[3:0]));
            return t[7:0];
        end
        case (a)
            7'h01: return {6'd0, mChsel};
            7'h02: return {6'd0, mMode};
            7'h03: return mThresh;
            7'h06: return {7'd0, mRun};
            7'h10: return res;
            default: return 8'h00;
        endcase
    endfunction

    task automatic applyWrite(input logic [6:0] a, input logic [7:0] d);
        case (a)
            7'h00: mBurst = d;
            7'h01: mChsel = d[1:0];
            7'h02: mMode = d[1:0];
            7'h03: mThresh = d;
            7'h04: mSeed = {mSeed[119:0], d};
            7'h05: begin
                mS0[mChsel] = (mSeed == 0) ? 64'd1 : mSeed[63:0];
                mS1[mChsel] = (mSeed == 0) ? 64'd0 : mSeed[127:64];
            end
            7'h06: mRun = d[0];
            default: ;
        endcase
    endtask

    // One clock edge; the model steps with the values that held at that edge
    task automatic cyc();
        logic [127:0] t;
        @(posedge clk);
        if (!rst && cg && mRun) begin
            for (int c = 0; c < NCH; c++) begin
                t = xoroNext({mS1[c], mS0[c]});
                mS0[c] = t[63:0];
                mS1[c] = t[127:64];
            end
        end
        #1;
    endtask

    task automatic waitRdy();
        int n;
        n = 0;
        while (!outRdy && n < 200) begin
            cyc();
            n++;
        end
        if (!outRdy) begin
            fails++;
            tests++;
            $display("FAIL ready_timeout: o_bp_ready %b, expected 1", outRdy);
        end
    endtask

    task automatic readReg(input logic [6:0] a);
        int n;
        logic [3:0] lo;
        logic [6:0] ak;
        inVld = 1'b1;
        inDat = {1'b0, a};
        waitRdy();
        n = (mBurst != 0 && a != 0) ? int'(mBurst) + 1 : 1;
        for (int k = 0; k < n; k++) begin
            lo = a[3:0] + 4'(k);
            ak = (a[6:4] == 3'b010) ? {a[6:4], lo} : a;
            expQ.push_back(readAt(ak, k));
        end
        if (n > 1) mBurst = 0;
        cyc();
        inVld = 1'b0;
    endtask

    task automatic writeReg(input logic [6:0] a, input logic [7:0] d);
        inVld = 1'b1;
        inDat = {1'b1, a};
        waitRdy();
        cyc();
        inDat = d;
        waitRdy();
        expQ.push_back((a == 7'h00) ? mBurst : readAt(a, 0));
        cyc();
        applyWrite(a, d);
        inVld = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((expQ.size() != 0 || outVld) && n < 300) begin
            cyc();
            n++;
        end
        if (expQ.size() != 0 || outVld) begin
            fails++;
            tests++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", expQ.size());
        end
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        expQ.delete();
        resetModel();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // response-side ready generator
    initial begin
        bpRdyIn = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (holdRdy) bpRdyIn = 1'b0;
            else if (mRun || !rndRdy) bpRdyIn = 1'b1;
            else bpRdyIn = ($urandom_range(0, 3) != 0);
        end
    end

    // scoreboard monitor
    initial begin
        logic       stalled;
        logic [7:0] stallDat;
        stalled = 1'b0;
        stallDat = 8'h00;
        forever begin
            @(negedge clk);
            if (rst || !outVld) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("stall_stable", outDat, stallDat);
                if (bpRdyIn) begin
                    if (expQ.size() == 0) begin
                        fails++;
                        tests++;
                        $display("FAIL unexpected_resp: got %h, expected no response", outDat);
                    end else begin
                        check("resp", outDat, expQ.pop_front());
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    stallDat = outDat;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [6:0] others [6];
        int op;
        logic [7:0] d;
        others = '{7'h00, 7'h04, 7'h05, 7'h07, 7'h30, 7'h7F};
        rst = 1'b1; cg = 1'b1; inVld = 1'b0; inDat = 8'h00;
        resetModel();
        repeat (3) cyc();
        check("rst_valid", {7'd0, outVld}, 8'h00);
        check("rst_ready", {7'd0, outRdy}, 8'h01);
        check("rst_data", outDat, 8'h00);
        rst = 1'b0;
        cyc();

        // directed register-map walk
        readReg(7'h10);
        writeReg(7'h02, 8'h01);
        readReg(7'h10);
        writeReg(7'h01, 8'h07);
        readReg(7'h01);
        writeReg(7'h01, 8'h00);
        writeReg(7'h00, 8'h03);
        readReg(7'h20);
        waitIdle();
        readReg(7'h00);
        writeReg(7'h00, 8'h02);
        readReg(7'h2E);
        cyc();
        holdRdy = 1'b1;
        repeat (5) cyc();
        holdRdy = 1'b0;
        waitIdle();
        for (int i = 0; i < 16; i++) writeReg(7'h04, 8'h00);
        writeReg(7'h01, 8'h01);
        writeReg(7'h05, 8'h5A);
        readReg(7'h20);
        readReg(7'h28);
        writeReg(7'h06, 8'h01);
        writeReg(7'h02, 8'h02);
        writeReg(7'h03, 8'h00);
        readReg(7'h10);
        waitIdle();

        // reset while a response is held
        holdRdy = 1'b1;
        readReg(7'h02);
        check("resp_valid_held", {7'd0, outVld}, 8'h01);
        #2 rst = 1'b1;
        #1 check("async_abort_valid", {7'd0, outVld}, 8'h00);
        check("async_abort_ready", {7'd0, outRdy}, 8'h01);
        holdRdy = 1'b0;
        expQ.delete();
        resetModel();
        cyc();
        rst = 1'b0;
        readReg(7'h02);
        // reset between a write command and its data byte
        inVld = 1'b1;
        inDat = 8'h83;
        waitIdle();
        waitRdy();
        cyc();
        inDat = 8'h77;
        #1 rst = 1'b1;
        inVld = 1'b0;
        resetModel();
        cyc();
        rst = 1'b0;
        readReg(7'h03);
        waitIdle();

        // random traffic
        rndRdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 11);
            d = 8'($urandom);
            case (op)
                0: writeReg(7'h01, d);
                1: writeReg(7'h02, d);
                2: writeReg(7'h03, d);
                3: writeReg(7'h06, d);
                4: if (!mRun) writeReg(7'h00, 8'($urandom_range(0, 5)));
                   else readReg(7'h10);
                5: writeReg(7'h04, d);
                6: writeReg(7'h05, d);
                7: readReg(7'h10);
                8: readReg(7'h20 | 7'($urandom_range(0, 15)));
                9: readReg(7'($urandom_range(0, 6)));
                10: if (d[0]) writeReg(others[$urandom_range(0, 5)], d);
                    else readReg(others[$urandom_range(0, 5)]);
                default: begin
                    waitIdle();
                    cg = 1'b0;
                    repeat ($urandom_range(1, 4)) cyc();
                    cg = 1'b1;
                end
            endcase
        end
        waitIdle();
        repeat (3) cyc();
        check("leftover_expected", 8'(expQ.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
